// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and memory port bundle for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    logic              busy;

    // Arbiter side: serves both requesters and drives the memory port.
    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata,
        input  m_ack, m_rdata,
        output busy
    );

    // Environment side: requesters plus the memory.
    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata,
        output m_ack, m_rdata,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one req/ack 64-bit memory port between fetch and data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STREAK_MAX = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_port_arbiter_if.slave bus
);

    localparam int              c_SW     = (STREAK_MAX > 0) ? $clog2(STREAK_MAX + 1) : 1;
    localparam logic [c_SW-1:0] c_SMAX   = c_SW'(STREAK_MAX);

    localparam logic [1:0]      c_IDLE   = 2'd0;
    localparam logic [1:0]      c_BUSY_I = 2'd1;
    localparam logic [1:0]      c_BUSY_D = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_SW-1:0]   r_streak;
    logic              r_hi;

    logic              r_m_req;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic              r_i_rvalid;
    logic [31:0]       r_i_rdata;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_idle;
    logic              w_streak_full;
    logic              w_d_gnt;
    logic              w_i_gnt;
    logic              w_ack;
    logic              w_unused_bits;

    // Alignment bits below the word/half-word select carry no information.
    assign w_unused_bits = ^{bus.i_addr[1:0], bus.d_addr[2:0]};

    always_comb begin
        w_idle        = (r_state == c_IDLE);
        w_streak_full = (r_streak == c_SMAX);
        w_d_gnt       = rst & w_idle & bus.d_req & ~(bus.i_req & w_streak_full);
        w_i_gnt       = rst & w_idle & bus.i_req & ~w_d_gnt;
        w_ack         = ~w_idle & bus.m_ack;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_d_gnt) begin
                    w_state_nxt = c_BUSY_D;
                end else if (w_i_gnt) begin
                    w_state_nxt = c_BUSY_I;
                end
            end
            c_BUSY_I, c_BUSY_D: begin
                if (bus.m_ack) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_streak   <= '0;
            r_hi       <= 1'b0;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;

            if (w_d_gnt) begin
                r_m_req   <= 1'b1;
                r_m_we    <= bus.d_we;
                r_m_addr  <= {bus.d_addr[ADDR_W-1:3], 3'b000};
                r_m_wdata <= bus.d_wdata;
                // Streak only grows while fetch is actually being held off.
                if (!bus.i_req) begin
                    r_streak <= '0;
                end else if (!w_streak_full) begin
                    r_streak <= r_streak + c_SW'(1);
                end
            end else if (w_i_gnt) begin
                r_m_req  <= 1'b1;
                r_m_we   <= 1'b0;
                r_m_addr <= {bus.i_addr[ADDR_W-1:3], 3'b000};
                r_hi     <= bus.i_addr[2];
                r_streak <= '0;
            end

            if (w_ack) begin
                r_m_req <= 1'b0;
                if (r_state == c_BUSY_I) begin
                    r_i_rvalid <= 1'b1;
                    r_i_rdata  <= r_hi ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
                end else begin
                    r_d_rvalid <= 1'b1;
                    if (!r_m_we) begin
                        r_d_rdata <= bus.m_rdata;
                    end
                end
            end
        end
    end

    assign bus.i_gnt    = w_i_gnt;
    assign bus.d_gnt    = w_d_gnt;
    assign bus.i_rvalid = r_i_rvalid;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.m_req    = r_m_req;
    assign bus.m_we     = r_m_we;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.busy     = ~w_idle;

endmodule

`default_nettype wire
